regfile_wb_arbiter: RTL and testbench

Writeback arbiter and pending-write scoreboard for the LC-3 8x16 register file. It accepts destination-register writes from two requesters: requester A is the ALU/datapath bus and requester B is the memory-load return. It grants one write per cycle, round-robin, and drives the register file write port (load enable, DR index, bus value) from a registered output stage. It also tracks which of R0–R7 have an outstanding reserved write so the control FSM can stall source reads.

---
 rtl/regfile_wb_arbiter.sv | 86 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard for the LC-3 8x16 register file.
// Optional build macro: WB_ARB_FIXED_PRIO_EN (fixed priority, A wins ties).
module regfile_wb_arbiter #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [$clog2(NREG)-1:0] a_dr,
  input  logic [DW-1:0]           a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [$clog2(NREG)-1:0] b_dr,
  input  logic [DW-1:0]           b_data,
  input  logic                    hold,
  input  logic                    rsv_valid,
  input  logic [$clog2(NREG)-1:0] rsv_dr,
  output logic                    LD_REG,
  output logic [$clog2(NREG)-1:0] wr_dr,
  output logic [DW-1:0]           BUS_Val,
  output logic [NREG-1:0]         pending
);

  logic            grant_a;
  logic            grant_b;
  logic [NREG-1:0] pend_next;

`ifdef WB_ARB_FIXED_PRIO_EN
  always_comb begin
    a_ready = !reset && !hold && a_valid;
    b_ready = !reset && !hold && b_valid && !a_valid;
  end
`else
  typedef enum logic {GRANT_A, GRANT_B} grant_t;
  grant_t last_grant;

  // On a tie the requester that did not win most recently gets the port.
  always_comb begin
    a_ready = !reset && !hold && a_valid && (!b_valid || last_grant == GRANT_B);
    b_ready = !reset && !hold && b_valid && (!a_valid || last_grant == GRANT_A);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset)
      last_grant <= GRANT_B;
    else if (grant_a)
      last_grant <= GRANT_A;
    else if (grant_b)
      last_grant <= GRANT_B;
  end
`endif

  assign grant_a = a_valid && a_ready;
  assign grant_b = b_valid && b_ready;

  // Clear applies first so a same-index reservation survives the write.
  always_comb begin
    pend_next = pending;
    if (LD_REG)
      pend_next[wr_dr] = 1'b0;
    if (rsv_valid)
      pend_next[rsv_dr] = 1'b1;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      LD_REG  <= 1'b0;
      wr_dr   <= '0;
      BUS_Val <= '0;
      pending <= '0;
    end else begin
      LD_REG  <= grant_a || grant_b;
      pending <= pend_next;
      if (grant_a) begin
        wr_dr   <= a_dr;
        BUS_Val <= a_data;
      end else if (grant_b) begin
        wr_dr   <= b_dr;
        BUS_Val <= b_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter; expectations adapt to WB_ARB_FIXED_PRIO_EN.
module tb_regfile_wb_arbiter;

`ifdef WB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [2:0]  a_dr, b_dr, rsv_dr, wr_dr;
  logic [15:0] a_data, b_data, BUS_Val;
  logic        hold, rsv_valid, LD_REG;
  logic [7:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.NREG(8), .DW(16)) dut (
    .Clk(Clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_dr(a_dr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dr(b_dr), .b_data(b_data),
    .hold(hold), .rsv_valid(rsv_valid), .rsv_dr(rsv_dr),
    .LD_REG(LD_REG), .wr_dr(wr_dr), .BUS_Val(BUS_Val), .pending(pending)
  );

  typedef struct {
    logic        av;
    logic [2:0]  adr;
    logic [15:0] adat;
    logic        bv;
    logic [2:0]  bdr;
    logic [15:0] bdat;
    logic        hld;
    logic        rv;
    logic [2:0]  rdr;
    logic        ea;
    logic        eb;
    logic        eld;
    logic [2:0]  ewr;
    logic [15:0] ebus;
    logic [7:0]  epend;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_valid = v.av; a_dr = v.adr; a_data = v.adat;
    b_valid = v.bv; b_dr = v.bdr; b_data = v.bdat;
    hold = v.hld; rsv_valid = v.rv; rsv_dr = v.rdr;
  endtask

  initial begin
    // Contention section: round-robin alternates A,B,A,B; fixed priority keeps A.
    //            av adr adat      bv bdr bdat      hld rv rdr ea  eb          eld ewr           ebus                      epend
    vecs[0]  = '{1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 1, 0,           1, 3,            16'h1234,                 8'h00};
    vecs[1]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0,           0, 3,            16'h1234,                 8'h00};
    vecs[2]  = '{0, 0, 16'h0000, 1, 2, 16'hBBBB, 0, 0, 0, 0, 1,           1, 2,            16'hBBBB,                 8'h00};
    vecs[3]  = '{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 1, 0,           1, 1,            16'hAAAA,                 8'h00};
    vecs[4]  = '{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, FIXED, !FIXED,  1, FIXED ? 3'd1 : 3'd2, FIXED ? 16'hAAAA : 16'hBBBB, 8'h00};
    vecs[5]  = '{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 1, 0,           1, 1,            16'hAAAA,                 8'h00};
    vecs[6]  = '{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, FIXED, !FIXED,  1, FIXED ? 3'd1 : 3'd2, FIXED ? 16'hAAAA : 16'hBBBB, 8'h00};
    vecs[7]  = '{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 1, 0, 0, 0, 0,           0, FIXED ? 3'd1 : 3'd2, FIXED ? 16'hAAAA : 16'hBBBB, 8'h00};
    vecs[8]  = '{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 1, 0, 0, 0, 0,           0, FIXED ? 3'd1 : 3'd2, FIXED ? 16'hAAAA : 16'hBBBB, 8'h00};
    vecs[9]  = '{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 1, 0, 0, 0, 0,           0, FIXED ? 3'd1 : 3'd2, FIXED ? 16'hAAAA : 16'hBBBB, 8'h00};
    vecs[10] = '{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 1, 0,           1, 1,            16'hAAAA,                 8'h00};
    // Scoreboard section.
    vecs[11] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 5, 0, 0,           0, 1,            16'hAAAA,                 8'h20};
    vecs[12] = '{0, 0, 16'h0000, 1, 5, 16'h0055, 0, 0, 0, 0, 1,           1, 5,            16'h0055,                 8'h20};
    vecs[13] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 5, 0, 0,           0, 5,            16'h0055,                 8'h20};
    vecs[14] = '{0, 0, 16'h0000, 1, 5, 16'h0066, 0, 0, 0, 0, 1,           1, 5,            16'h0066,                 8'h20};
    vecs[15] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0,           0, 5,            16'h0066,                 8'h00};
    vecs[16] = '{1, 4, 16'h4444, 0, 0, 16'h0000, 0, 1, 2, 1, 0,           1, 4,            16'h4444,                 8'h04};
    vecs[17] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 6, 0, 0,           0, 4,            16'h4444,                 8'h44};
    vecs[18] = '{1, 2, 16'h2222, 0, 0, 16'h0000, 0, 0, 0, 1, 0,           1, 2,            16'h2222,                 8'h44};
    vecs[19] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 3, 0, 0,           0, 2,            16'h2222,                 8'h48};

    reset = 1'b1;
    a_valid = 0; a_dr = '0; a_data = '0;
    b_valid = 0; b_dr = '0; b_data = '0;
    hold = 0; rsv_valid = 0; rsv_dr = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    #1;
    check("rst_ld", 0, LD_REG, 1'b0);
    check("rst_wr_dr", 0, wr_dr, 3'd0);
    check("rst_bus", 0, BUS_Val, 16'h0000);
    check("rst_pending", 0, pending, 8'h00);

    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      drive(vecs[i]);
      #1;
      check("a_ready", i, a_ready, vecs[i].ea);
      check("b_ready", i, b_ready, vecs[i].eb);
      @(posedge Clk);
      #1;
      check("LD_REG", i, LD_REG, vecs[i].eld);
      check("wr_dr", i, wr_dr, vecs[i].ewr);
      check("BUS_Val", i, BUS_Val, vecs[i].ebus);
      check("pending", i, pending, vecs[i].epend);
    end

    // Asynchronous reset while a write is registered and a request is pending.
    @(negedge Clk);
    a_valid = 1; a_dr = 3'd3; a_data = 16'h5555;
    b_valid = 0; hold = 0; rsv_valid = 1; rsv_dr = 3'd7;
    @(posedge Clk);
    #1;
    check("pre_rst_ld", 100, LD_REG, 1'b1);
    check("pre_rst_pending", 100, pending, 8'hC8);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ld", 101, LD_REG, 1'b0);
    check("mid_rst_wr_dr", 101, wr_dr, 3'd0);
    check("mid_rst_bus", 101, BUS_Val, 16'h0000);
    check("mid_rst_pending", 101, pending, 8'h00);
    check("mid_rst_a_ready", 101, a_ready, 1'b0);
    @(posedge Clk);
    #1;
    check("hold_rst_ld", 102, LD_REG, 1'b0);

    // First tie after reset goes to A.
    @(negedge Clk);
    rsv_valid = 0;
    b_valid = 1; b_dr = 3'd6; b_data = 16'h6666;
    reset = 1'b0;
    #1;
    check("tie_a_ready", 103, a_ready, 1'b1);
    check("tie_b_ready", 103, b_ready, 1'b0);
    @(posedge Clk);
    #1;
    check("tie_ld", 104, LD_REG, 1'b1);
    check("tie_wr_dr", 104, wr_dr, 3'd3);
    check("tie_bus", 104, BUS_Val, 16'h5555);
    @(negedge Clk);
    a_valid = 0; b_valid = 0;
    @(posedge Clk);
    #1;
    check("idle_ld", 105, LD_REG, 1'b0);
    check("idle_pending", 105, pending, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
